mem_stage_mc: RTL and testbench

MEM_STAGE_MC -- requirements
Module: mem_stage_mc

---
 rtl/mem_stage_mc_pkg.sv | 34 +++
 rtl/dest_parser.sv | 30 +++
 rtl/mem_fwd_hist.sv | 63 ++++++
 rtl/mem_stage_mc.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_mc.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_mc_pkg
// Description : Shared core definitions for the multi-cycle memory stage:
//               memory opcode constants, memory-op / write decode helpers
//               and the memory FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_mc_pkg;

    // Memory opcodes (instruction[15:11])
    localparam logic [4:0] C_OPC_ST  = 5'b10000;
    localparam logic [4:0] C_OPC_LD  = 5'b10001;
    localparam logic [4:0] C_OPC_STU = 5'b10011;

    // Memory-stage FSM: IDLE accepts a new request, WAIT holds an
    // outstanding one until the memory acknowledges it.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // 100xx except 10010 (which is not a memory access)
    function automatic logic is_mem_op(input logic [4:0] opcode);
        return (opcode[4:2] == 3'b100) && (opcode[1:0] != 2'b10);
    endfunction

    // Stores are the memory ops whose two low opcode bits agree (ST, STU)
    function automatic logic is_mem_write(input logic [4:0] opcode);
        return is_mem_op(opcode) && (opcode[1] == opcode[0]);
    endfunction

endpackage : mem_stage_mc_pkg
`default_nettype wire

// File: rtl/dest_parser.sv
`default_nettype none
// ============================================================================
// Module      : dest_parser
// Description : Combinational destination-register extraction for a 16-bit
//               instruction.
//   instr  in  16  instruction word
//   rd     out 3   destination register index
// Revision    : 1.0 - initial release
// ============================================================================
module dest_parser (
    input  logic [15:0] instr,
    output logic [2:0]  rd
);

    logic [4:0] opcode;
    assign opcode = instr[15:11];

    always_comb begin
        rd = instr[7:5];
        casez (opcode)
            5'b1101?, 5'b111??: rd = instr[4:2];   // register-register ops
            5'b10011,                              // STU writes back Rs
            5'b11000, 5'b10010: rd = instr[10:8];  // LBI / SLBI
            5'b0011?:           rd = 3'd7;         // JAL / JALR link
            default:            rd = instr[7:5];   // immediate ops, LD
        endcase
    end

endmodule : dest_parser
`default_nettype wire

// File: rtl/mem_fwd_hist.sv
`default_nettype none
// ============================================================================
// Module      : mem_fwd_hist
// Description : Shift-register history of recent writeback results used to
//               forward store data. Entry 0 is the youngest; every cycle a
//               new entry is pushed and the oldest one is dropped.
//   clk, rst              clock, asynchronous active-low reset
//   push_valid/rd/data    writeback entry pushed this cycle
//   query_rd              register being looked up
//   hit, hit_data         youngest valid entry matching query_rd
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fwd_hist #(
    parameter int DATA_W    = 16,
    parameter int FWD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [2:0]        push_rd,
    input  logic [DATA_W-1:0] push_data,
    input  logic [2:0]        query_rd,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic              r_v    [FWD_DEPTH];
    logic [2:0]        r_rd   [FWD_DEPTH];
    logic [DATA_W-1:0] r_data [FWD_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                r_v[i]    <= 1'b0;
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_v[0]    <= push_valid;
            r_rd[0]   <= push_rd;
            r_data[0] <= push_data;
            for (int i = 1; i < FWD_DEPTH; i++) begin
                r_v[i]    <= r_v[i-1];
                r_rd[i]   <= r_rd[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (r_v[i] && (r_rd[i] == query_rd)) begin
                hit      = 1'b1;
                hit_data = r_data[i];
            end
        end
    end

endmodule : mem_fwd_hist
`default_nettype wire

// File: rtl/mem_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_mc
// Description : Multi-cycle pipeline memory stage. Issues one memory request
//               per memory instruction, stalls upstream until the memory
//               acknowledges, forwards store data from recent writebacks and
//               registers results into the M/WB pipeline register.
//   in_valid/instruction_in/incrPC/Xcomp/write_data/RegWrt_in : X/M inputs
//   wb_regwrt/wb_rd/wb_rd_data : current writeback (forwarding source)
//   mem_req/mem_wr/mem_addr/mem_wdata, mem_rdata/mem_ack : memory port
//   stall : freeze upstream stages
//   out_valid/instruction_out/incrPC_out/Xcomp_out/read_data_out/RegWrt_out :
//           M/WB register outputs
//   xm_rd : destination register of instruction_in
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_mc
    import mem_stage_mc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FWD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       instruction_in,
    input  logic [DATA_W-1:0] incrPC,
    input  logic [DATA_W-1:0] Xcomp,
    input  logic [DATA_W-1:0] write_data,
    input  logic              RegWrt_in,
    input  logic              wb_regwrt,
    input  logic [2:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_rd_data,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              out_valid,
    output logic [15:0]       instruction_out,
    output logic [DATA_W-1:0] incrPC_out,
    output logic [DATA_W-1:0] Xcomp_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic              RegWrt_out,
    output logic [2:0]        xm_rd
);

    mem_state_t        r_state, w_state_nx;
    logic [DATA_W-1:0] r_cap_addr, r_cap_wdata;
    logic              r_cap_wr;

    logic              w_is_mem, w_is_wr, w_complete, w_capture;
    logic [2:0]        w_src_rd;
    logic              w_hist_hit;
    logic [DATA_W-1:0] w_hist_data, w_fwd_data;

    assign w_is_mem = in_valid && is_mem_op(instruction_in[15:11]);
    assign w_is_wr  = is_mem_write(instruction_in[15:11]);
    assign w_src_rd = instruction_in[7:5];

    dest_parser u_dest_parser (
        .instr (instruction_in),
        .rd    (xm_rd)
    );

    mem_fwd_hist #(
        .DATA_W    (DATA_W),
        .FWD_DEPTH (FWD_DEPTH)
    ) u_fwd_hist (
        .clk        (clk),
        .rst        (rst),
        .push_valid (wb_regwrt),
        .push_rd    (wb_rd),
        .push_data  (wb_rd_data),
        .query_rd   (w_src_rd),
        .hit        (w_hist_hit),
        .hit_data   (w_hist_data)
    );

    // The live writeback result is younger than anything in the history.
    always_comb begin
        if (wb_regwrt && (wb_rd == w_src_rd))
            w_fwd_data = wb_rd_data;
        else if (w_hist_hit)
            w_fwd_data = w_hist_data;
        else
            w_fwd_data = write_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = Xcomp;
        mem_wdata  = w_fwd_data;
        stall      = 1'b0;
        w_complete = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    mem_req = 1'b1;
                    mem_wr  = w_is_wr;
                    if (mem_ack) begin
                        w_complete = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        w_capture  = 1'b1;
                        w_state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_req   = 1'b1;
                mem_wr    = r_cap_wr;
                mem_addr  = r_cap_addr;
                mem_wdata = r_cap_wdata;
                if (mem_ack) begin
                    w_complete = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Freeze the request so the memory sees a stable address and data even
    // if the forwarding sources move on while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap_addr  <= '0;
            r_cap_wdata <= '0;
            r_cap_wr    <= 1'b0;
        end else if (w_capture) begin
            r_cap_addr  <= Xcomp;
            r_cap_wdata <= w_fwd_data;
            r_cap_wr    <= w_is_wr;
        end
    end

    // M/WB register: bubble on stall, otherwise load this cycle's instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid       <= 1'b0;
            RegWrt_out      <= 1'b0;
            instruction_out <= '0;
            incrPC_out      <= '0;
            Xcomp_out       <= '0;
            read_data_out   <= '0;
        end else if (stall) begin
            out_valid  <= 1'b0;
            RegWrt_out <= 1'b0;
        end else begin
            out_valid       <= in_valid;
            RegWrt_out      <= in_valid && RegWrt_in;
            instruction_out <= instruction_in;
            incrPC_out      <= incrPC;
            Xcomp_out       <= Xcomp;
            read_data_out   <= (w_complete && !mem_wr) ? mem_rdata : '0;
        end
    end

endmodule : mem_stage_mc
`default_nettype wire

// File: tb/tb_mem_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_mc
// Description : Self-checking bench for mem_stage_mc with a transaction-level
//               reference model (writeback history list, per-instruction
//               expected stall count and results).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_mc;

    localparam int DATA_W    = 16;
    localparam int FWD_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [15:0]       instruction_in = '0;
    logic [DATA_W-1:0] incrPC = '0, Xcomp = '0, write_data = '0;
    logic              RegWrt_in = 1'b0;
    logic              wb_regwrt = 1'b0;
    logic [2:0]        wb_rd = '0;
    logic [DATA_W-1:0] wb_rd_data = '0;
    logic              mem_req, mem_wr;
    logic [DATA_W-1:0] mem_addr, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              stall, out_valid, RegWrt_out;
    logic [15:0]       instruction_out;
    logic [DATA_W-1:0] incrPC_out, Xcomp_out, read_data_out;
    logic [2:0]        xm_rd;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model: list of recent writebacks, index 0 = most recent.
    logic              mh_v  [FWD_DEPTH];
    logic [2:0]        mh_rd [FWD_DEPTH];
    logic [DATA_W-1:0] mh_d  [FWD_DEPTH];

    always #5 clk = ~clk;

    mem_stage_mc #(.DATA_W(DATA_W), .FWD_DEPTH(FWD_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction_in(instruction_in),
        .incrPC(incrPC), .Xcomp(Xcomp), .write_data(write_data), .RegWrt_in(RegWrt_in),
        .wb_regwrt(wb_regwrt), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .out_valid(out_valid),
        .instruction_out(instruction_out), .incrPC_out(incrPC_out), .Xcomp_out(Xcomp_out),
        .read_data_out(read_data_out), .RegWrt_out(RegWrt_out), .xm_rd(xm_rd)
    );

    task automatic model_clear();
        for (int i = 0; i < FWD_DEPTH; i++) begin
            mh_v[i] = 1'b0; mh_rd[i] = '0; mh_d[i] = '0;
        end
    endtask

    task automatic model_push(input logic v, input logic [2:0] rd, input logic [DATA_W-1:0] d);
        for (int i = FWD_DEPTH - 1; i > 0; i--) begin
            mh_v[i] = mh_v[i-1]; mh_rd[i] = mh_rd[i-1]; mh_d[i] = mh_d[i-1];
        end
        mh_v[0] = v; mh_rd[0] = rd; mh_d[0] = d;
    endtask

    // Most recent value of register src: live writeback, then history, then decode value.
    function automatic logic [DATA_W-1:0] model_store_data(input logic [2:0] src,
            input logic wv, input logic [2:0] wr, input logic [DATA_W-1:0] wd,
            input logic [DATA_W-1:0] dec);
        if (wv && wr == src) return wd;
        for (int i = 0; i < FWD_DEPTH; i++)
            if (mh_v[i] && mh_rd[i] == src) return mh_d[i];
        return dec;
    endfunction

    // Runs one instruction through the stage. For memory ops the memory
    // acknowledges after 'delay' wait cycles; stall is expected in exactly
    // those cycles followed by a single valid M/WB entry.
    task automatic run_instr(input string nm, input logic [15:0] ins, input logic iv,
            input logic [DATA_W-1:0] xc, input logic [DATA_W-1:0] pc,
            input logic [DATA_W-1:0] wd, input logic rw,
            input logic wbv, input logic [2:0] wbr, input logic [DATA_W-1:0] wbd,
            input int delay_in, input logic ack_noise);
        logic memop, wr;
        int delay;
        logic [DATA_W-1:0] exp_wdata, rdata;
        memop = iv && (ins[15:13] == 3'b100) && (ins[12:11] != 2'b10);
        wr    = memop && (ins[12] == ins[11]);
        delay = memop ? delay_in : 0;
        in_valid = iv; instruction_in = ins; Xcomp = xc; incrPC = pc;
        write_data = wd; RegWrt_in = rw;
        wb_regwrt = wbv; wb_rd = wbr; wb_rd_data = wbd;
        exp_wdata = model_store_data(ins[7:5], wbv, wbr, wbd, wd);
        for (int k = 0; k <= delay; k++) begin
            logic sv; logic [2:0] sr; logic [DATA_W-1:0] sd;
            rdata = DATA_W'($urandom);
            mem_rdata = rdata;
            mem_ack = memop ? (k == delay) : ack_noise;
            @(negedge clk);
            total_cnt++;
            if (mem_req !== memop || stall !== (k < delay)) begin
                $display("FAIL %s req/stall k=%0d: got req=%b stall=%b want req=%b stall=%b",
                         nm, k, mem_req, stall, memop, (k < delay));
            end else pass_cnt++;
            if (memop) begin
                total_cnt++;
                if (mem_addr !== xc || mem_wr !== wr) begin
                    $display("FAIL %s addr/wr k=%0d: got %h/%b want %h/%b", nm, k, mem_addr, mem_wr, xc, wr);
                end else pass_cnt++;
                if (wr) begin
                    total_cnt++;
                    if (mem_wdata !== exp_wdata) begin
                        $display("FAIL %s wdata k=%0d: got %h want %h", nm, k, mem_wdata, exp_wdata);
                    end else pass_cnt++;
                end
            end
            sv = wb_regwrt; sr = wb_rd; sd = wb_rd_data;
            @(posedge clk); #1;
            model_push(sv, sr, sd);
            if (k < delay) begin
                total_cnt++;
                if (out_valid !== 1'b0 || RegWrt_out !== 1'b0) begin
                    $display("FAIL %s bubble k=%0d: got valid=%b regwrt=%b want 0/0", nm, k, out_valid, RegWrt_out);
                end else pass_cnt++;
                // Sources move on while the request waits; the request must not.
                write_data = DATA_W'($urandom);
                wb_regwrt = 1'($urandom); wb_rd = 3'($urandom); wb_rd_data = DATA_W'($urandom);
            end else begin
                total_cnt++;
                if (out_valid !== iv || RegWrt_out !== (iv && rw) ||
                    instruction_out !== ins || Xcomp_out !== xc || incrPC_out !== pc ||
                    read_data_out !== ((memop && !wr) ? rdata : '0)) begin
                    $display("FAIL %s mwb: got v=%b rw=%b ins=%h x=%h pc=%h rd=%h want v=%b rw=%b ins=%h x=%h pc=%h rd=%h",
                             nm, out_valid, RegWrt_out, instruction_out, Xcomp_out, incrPC_out, read_data_out,
                             iv, (iv && rw), ins, xc, pc, ((memop && !wr) ? rdata : '0));
                end else pass_cnt++;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic nop_wb(input logic wbv, input logic [2:0] wbr, input logic [DATA_W-1:0] wbd);
        run_instr("nop", 16'h0800, 1'b1, 16'h0, 16'h2, 16'h0, 1'b0, wbv, wbr, wbd, 0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        #12;
        total_cnt++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || out_valid !== 1'b0 || RegWrt_out !== 1'b0 ||
            instruction_out !== '0 || incrPC_out !== '0 || Xcomp_out !== '0 || read_data_out !== '0) begin
            $display("FAIL reset: got req=%b stall=%b v=%b rw=%b ins=%h pc=%h x=%h rd=%h want all 0",
                     mem_req, stall, out_valid, RegWrt_out, instruction_out, incrPC_out, Xcomp_out, read_data_out);
        end else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_same_cycle();
        run_instr("load0", {5'b10001, 11'h0A3}, 1'b1, 16'h0040, 16'h0102, 16'h0, 1'b1,
                  1'b0, 3'd0, 16'h0, 0, 1'b0);
    endtask

    task automatic test_store_delay3();
        run_instr("store3", {5'b10000, 11'h0C5}, 1'b1, 16'h1230, 16'h0200, 16'h5A5A, 1'b0,
                  1'b0, 3'd0, 16'h0, 3, 1'b0);
    endtask

    task automatic test_fwd_history();
        nop_wb(1'b1, 3'd3, 16'h1111);
        nop_wb(1'b1, 3'd3, 16'h2222);
        // store sourcing r3 (bits [7:5] = 3)
        run_instr("fwd_r3", {5'b10000, 3'b001, 3'd3, 5'b00000}, 1'b1, 16'h0080, 16'h0300,
                  16'h0000, 1'b0, 1'b0, 3'd0, 16'h0, 1, 1'b0);
    endtask

    task automatic test_no_fwd_r0();
        for (int i = 0; i < FWD_DEPTH; i++) nop_wb(1'b0, 3'd0, 16'hFFFF);
        run_instr("nofwd_r0", {5'b10011, 3'b010, 3'd0, 5'b00000}, 1'b1, 16'h0090, 16'h0400,
                  16'hBEEF, 1'b1, 1'b0, 3'd0, 16'h1234, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [15:0] ins;
            logic [4:0] op;
            case ($urandom_range(0, 4))
                0: op = 5'b10000;
                1: op = 5'b10001;
                2: op = 5'b10011;
                default: op = 5'($urandom);
            endcase
            ins = {op, 11'($urandom)};
            run_instr("rand", ins, ($urandom_range(0, 9) != 0), DATA_W'($urandom), DATA_W'($urandom),
                      DATA_W'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), DATA_W'($urandom),
                      $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_reset_in_wait();
        in_valid = 1'b1; instruction_in = {5'b10000, 11'h011}; Xcomp = 16'h0700;
        write_data = 16'h7777; RegWrt_in = 1'b0; wb_regwrt = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (stall !== 1'b1 || mem_req !== 1'b1) begin
            $display("FAIL wait_entry: got stall=%b req=%b want 1/1", stall, mem_req);
        end else pass_cnt++;
        #2 rst = 1'b0; in_valid = 1'b0; mem_ack = 1'b1;
        #1;
        model_clear();
        total_cnt++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL rst_in_wait: got req=%b stall=%b v=%b want 0/0/0", mem_req, stall, out_valid);
        end else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total_cnt++;
            if (mem_req !== 1'b0 || stall !== 1'b0) begin
                $display("FAIL post_rst_req k=%0d: got req=%b stall=%b want 0/0", k, mem_req, stall);
            end else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b0 || read_data_out !== '0) begin
                $display("FAIL post_rst_out k=%0d: got v=%b rd=%h want 0/0", k, out_valid, read_data_out);
            end else pass_cnt++;
        end
        mem_ack = 1'b0;
        model_push(1'b0, 3'd0, '0);
        model_push(1'b0, 3'd0, '0);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_load_same_cycle();
        test_store_delay3();
        test_fwd_history();
        test_no_fwd_r0();
        test_random();
        test_reset_in_wait();
        test_fwd_history();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_mem_stage_mc
`default_nettype wire
